uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  Parametrised UART transmitter: serialises one DATA_WIDTH-bit word per frame, LSB first.
//  Frame: start bit, data bits, optional parity bit, 1 or 2 stop bits.
//  Takes words over a valid/ready handshake so a FIFO or arbiter can stream back-to-back frames.
//  Sits between the transceiver datapath and the TX pad.
// PARAMETERS
//  CLOCK_RATE   1_000_000  clk frequency, Hz
//  BAUD_RATE    115_200    line rate, bit/s; CLK_PER_BIT = CLOCK_RATE/BAUD_RATE (floor), must be >= 2
//  DATA_WIDTH   8          data bits per frame, legal range 5..9
//  STOP_BITS    1          stop bits per frame, 1 or 2
//  PARITY_ODD   0          0 = even parity, 1 = odd parity; used only with UART_TX_PARITY_EN
// PORTS
//  clk      in   1           clock
//  arst     in   1           asynchronous reset, active-high
//  s_valid  in   1           word on s_data is valid
//  s_data   in   DATA_WIDTH  word to transmit
//  s_ready  out  1           block can accept a word this cycle
//  busy     out  1           frame in progress, start through last stop bit
//  done     out  1           one-cycle pulse: frame completed
//  q        out  1           serial line, idle high
// BEHAVIOUR
//  Reset (async, arst=1): q=1, busy=0, done=0, s_ready=0 while arst high, s_ready=1 from first clk after release.
//   State=IDLE; counters=0; any frame in flight is abandoned with no done pulse.
//  Handshake: word accepted on a rising edge with s_valid&s_ready; s_data captured into shift register.
//   s_ready=1 only in IDLE. s_data is ignored when not accepted.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: q=1. On accept go to START, busy=1 from next cycle.
//   START: q=0 for exactly CLK_PER_BIT cycles. The first START cycle is the cycle after accept.
//   DATA: DATA_WIDTH bits, LSB first, each held exactly CLK_PER_BIT cycles.
//    bit_cnt counts 0..DATA_WIDTH-1; leave DATA after bit DATA_WIDTH-1 completes.
//   PARITY (macro only): q = XOR of data bits (even), or its inverse (odd), for CLK_PER_BIT cycles.
//   STOP: q=1 for STOP_BITS*CLK_PER_BIT cycles. On the final STOP cycle, next state is IDLE.
//  done: 1 for exactly one cycle, the first IDLE cycle after STOP; busy=0 in that same cycle.
//  Back-to-back frames: s_ready=1 in the done cycle. Accept there puts the next start bit one cycle later.
//   Minimum line-high gap between frames = STOP_BITS*CLK_PER_BIT + 1 cycles.
//  Frame length, accept to done: (1+DATA_WIDTH+P+STOP_BITS)*CLK_PER_BIT + 1 cycles, P = 1 with parity, else 0.
//  Counters: clk_cnt width $clog2(CLK_PER_BIT*STOP_BITS)+1, runs 0..limit-1, resets to 0 on each bit boundary.
//   Never wraps mid-bit.
//  Registered output: q comes straight from a flop, with no glitch on state change.
//  s_valid held high continuously gives frames spaced at the minimum gap, with no lost or duplicated word.
//  Illegal parameters (CLK_PER_BIT<2, DATA_WIDTH outside 5..9, STOP_BITS not 1/2): $error at elaboration.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state present; parity computed from the captured word and sent after the last data bit.
//   PARITY_ODD selects the sense.
//  UART_TX_PARITY_EN undefined: no PARITY state or logic; DATA goes directly to STOP; PARITY_ODD ignored.
// TESTING
//  (CLOCK_RATE=1_000_000, BAUD_RATE=100_000 -> CLK_PER_BIT=10 unless stated)
//  1. 8N1, send 8'hA5 -> q: 10 cycles 0, then 1,0,1,0,0,1,0,1 (10 each), then 10 cycles 1.
//     done pulse 101 cycles after accept.
//  2. Parity on, PARITY_ODD=0, send 8'hA5 -> parity bit 0. PARITY_ODD=1 -> parity bit 1. Frame accept-to-done 111 cycles.
//  3. STOP_BITS=2, s_valid held high with 8'h00 then 8'hFF -> second start bit begins exactly 21 cycles after the first frame's last data bit ends.
//     s_ready high only in done cycles.
//  4. arst pulsed during the 4th data bit of 8'h3C -> q=1 immediately, busy=0, no done pulse.
//     Next accepted 8'h81 transmits correctly.
//  5. DATA_WIDTH=5, send 5'h1F with s_valid pulsed while busy -> mid-frame pulse ignored.
//     q shows start, five 1s, stop, and exactly one done.

Source files
------------

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter. Serialises one DATA_WIDTH-bit word per frame, LSB
//   first: start bit, data bits, optional parity bit, STOP_BITS stop bits.
//   Words arrive over a valid/ready handshake so an upstream FIFO or arbiter
//   can stream frames back to back.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> a parity bit follows the last data bit. The bit is even
//                  parity, or odd parity when PARITY_ODD = 1.
//     undefined -> no parity state or logic. DATA goes straight to STOP.
//
// Ports
//   clk      in   1           clock
//   arst     in   1           asynchronous reset, active-high
//   s_valid  in   1           word on s_data is valid
//   s_data   in   DATA_WIDTH  word to transmit
//   s_ready  out  1           block can accept a word this cycle (IDLE only)
//   busy     out  1           frame in progress, start through last stop bit
//   done     out  1           one-cycle pulse in the first IDLE cycle after STOP
//   q        out  1           serial line, idle high, driven from a flop
//
// Handshake: a word transfers on a rising clk edge where s_valid && s_ready.
//   The producer may hold s_valid for any time. s_data is only sampled on the
//   transfer edge. s_ready does not depend on s_valid.
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int CLOCK_RATE = 1_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  q
);

  localparam int CLK_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int STOP_LEN    = CLK_PER_BIT * STOP_BITS;
  localparam int CW          = $clog2(STOP_LEN) + 1;
  localparam int BW          = $clog2(DATA_WIDTH);

  if (CLK_PER_BIT < 2) begin : g_bad_clk_per_bit
    $error("uart_tx_frame: CLOCK_RATE/BAUD_RATE must be >= 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx_frame: DATA_WIDTH must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         clk_cnt, clk_cnt_nx;
  logic [BW-1:0]         bit_cnt, bit_cnt_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic                  q_r, q_nx;
  logic                  done_r, done_nx;
  logic                  ready_en;
  logic                  accept;
  logic                  bit_end;
  logic                  stop_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_r, par_nx;
`endif

  assign accept   = s_valid && s_ready;
  assign bit_end  = (clk_cnt == CW'(CLK_PER_BIT - 1));
  assign stop_end = (clk_cnt == CW'(STOP_LEN - 1));

  // ready_en keeps s_ready low while arst is high and for the rest of that
  // cycle. s_ready rises at the first clk edge after release.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= ST_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      q_r     <= 1'b1;
      done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      clk_cnt <= clk_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      q_r     <= q_nx;
      done_r  <= done_nx;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    clk_cnt_nx = clk_cnt + CW'(1);
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    done_nx    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nx     = par_r;
`endif
    case (state)
      ST_IDLE: begin
        clk_cnt_nx = '0;
        if (accept) begin
          state_nx   = ST_START;
          shreg_nx   = s_data;
          bit_cnt_nx = '0;
`ifdef UART_TX_PARITY_EN
          par_nx     = (^s_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          clk_cnt_nx = '0;
          state_nx   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          clk_cnt_nx = '0;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_nx = '0;
`ifdef UART_TX_PARITY_EN
            state_nx   = ST_PARITY;
`else
            state_nx   = ST_STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + BW'(1);
            // The bit on the line is always shreg[0].
            shreg_nx   = shreg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          clk_cnt_nx = '0;
          state_nx   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // The stop phase counts all stop bits as one STOP_LEN interval.
        if (stop_end) begin
          clk_cnt_nx = '0;
          state_nx   = ST_IDLE;
          done_nx    = 1'b1;
        end
      end
      default: begin
        clk_cnt_nx = '0;
        state_nx   = ST_IDLE;
      end
    endcase

    // The line level is decoded from the next state and registered. q then
    // changes exactly on the edge that enters a bit, with no decode glitches.
    case (state_nx)
      ST_START:  q_nx = 1'b0;
      ST_DATA:   q_nx = shreg_nx[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: q_nx = par_nx;
`endif
      default:   q_nx = 1'b1;
    endcase
  end

  assign s_ready = ready_en && (state == ST_IDLE);
  assign busy    = (state != ST_IDLE);
  assign done    = done_r;
  assign q       = q_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
//   Directed bench for uart_tx_frame with CLK_PER_BIT = 10. It uses three
//   instances:
//     dut0: 8 data bits, 1 stop bit, even parity sense
//     dut1: 8 data bits, 2 stop bits
//     dut2: 5 data bits, 1 stop bit, odd parity sense
//   sel chooses which instance the driver tasks and frame checker address.
//   The expected line level for each cycle comes from the frame layout. This
//   layout is start, data LSB first, [parity], stop.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int C = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  // clock / reset
  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [4:0] d2 = '0;
  logic       r0, r1, r2, b0, b1, b2, dn0, dn1, dn2, q0, q1, q2;

  uart_tx_frame #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                  .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .arst(arst), .s_valid(v0), .s_data(d0),
    .s_ready(r0), .busy(b0), .done(dn0), .q(q0));

  uart_tx_frame #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                  .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .arst(arst), .s_valid(v1), .s_data(d1),
    .s_ready(r1), .busy(b1), .done(dn1), .q(q1));

  uart_tx_frame #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(5),
                  .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .arst(arst), .s_valid(v2), .s_data(d2),
    .s_ready(r2), .busy(b2), .done(dn2), .q(q2));

  int   sel = 0;
  logic q_m, b_m, dn_m, r_m;
  always_comb begin
    case (sel)
      1:       begin q_m = q1; b_m = b1; dn_m = dn1; r_m = r1; end
      2:       begin q_m = q2; b_m = b2; dn_m = dn2; r_m = r2; end
      default: begin q_m = q0; b_m = b0; dn_m = dn0; r_m = r0; end
    endcase
  end

  int checks = 0;
  int errors = 0;
  int frame_start_cyc = 0;
  int last_low_cyc = 0;

  // driver tasks
  task automatic drive(input logic v, input logic [8:0] d);
    case (sel)
      1:       begin v1 = v; d1 = d[7:0]; end
      2:       begin v2 = v; d2 = d[4:0]; end
      default: begin v0 = v; d0 = d[7:0]; end
    endcase
  endtask

  // Presents a word and returns just after the transfer edge. s_valid stays
  // high, so the caller decides whether to drop it.
  task automatic accept(input logic [8:0] w, input string name);
    @(negedge clk);
    drive(1'b1, w);
    checks++;
    if (r_m !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: s_ready=%b expected 1", name, r_m);
    end
    @(posedge clk);
    #1;
  endtask

  // Checks cycles 1..min(total, max_n) after a transfer edge. Cycle n is
  // sampled on the n-th falling edge. With pulse_at > 0, a one-cycle s_valid
  // pulse (data 0) is driven in that cycle.
  task automatic run_frame(input logic [8:0] w, input int dw, input int sb,
                           input int odd, input int max_n, input int pulse_at,
                           input string name);
    int   total;
    int   b;
    logic par;
    logic exp_q;
    total = (1 + dw + P + sb) * C + 1;
    par = (odd != 0);
    for (int i = 0; i < dw; i++) par = par ^ w[i];
    for (int n = 1; n <= total && n <= max_n; n++) begin
      @(negedge clk);
      if (pulse_at > 0 && n == pulse_at)     drive(1'b1, 9'h000);
      if (pulse_at > 0 && n == pulse_at + 1) drive(1'b0, 9'h000);
      if (n == 1) frame_start_cyc = cyc;
      if (q_m === 1'b0) last_low_cyc = cyc;
      b = (n - 1) / C;
      if (b == 0)                       exp_q = 1'b0;
      else if (b <= dw)                 exp_q = w[b-1];
      else if (P == 1 && b == dw + 1)   exp_q = par;
      else                              exp_q = 1'b1;
      checks++;
      if (q_m !== exp_q) begin
        errors++;
        if (errors < 40) $display("FAIL %s q cycle %0d: got %b expected %b", name, n, q_m, exp_q);
      end
      checks++;
      if (b_m !== (n < total)) begin
        errors++;
        if (errors < 40) $display("FAIL %s busy cycle %0d: got %b expected %b", name, n, b_m, n < total);
      end
      checks++;
      if (dn_m !== (n == total)) begin
        errors++;
        if (errors < 40) $display("FAIL %s done cycle %0d: got %b expected %b", name, n, dn_m, n == total);
      end
      checks++;
      if (r_m !== (n == total)) begin
        errors++;
        if (errors < 40) $display("FAIL %s s_ready cycle %0d: got %b expected %b", name, n, r_m, n == total);
      end
    end
  endtask

  // Checks that the selected instance stays quiet for a number of cycles.
  task automatic check_quiet(input int cycles, input string name);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      checks++;
      if (dn_m !== 1'b0 || b_m !== 1'b0 || q_m !== 1'b1) begin
        errors++;
        $display("FAIL %s quiet cycle %0d: done=%b busy=%b q=%b expected 0 0 1", name, n, dn_m, b_m, q_m);
      end
    end
  endtask

  // scenarios
  task automatic test_reset;
    sel = 0;
    #12;
    checks++;
    if ({q0, b0, dn0, r0} !== 4'b1000) begin
      errors++;
      $display("FAIL reset dut0: q,busy,done,s_ready=%b expected 1000", {q0, b0, dn0, r0});
    end
    checks++;
    if ({q1, b1, dn1, r1, q2, b2, dn2, r2} !== 8'b1000_1000) begin
      errors++;
      $display("FAIL reset dut1/2: got %b expected 10001000", {q1, b1, dn1, r1, q2, b2, dn2, r2});
    end
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({r0, r1, r2} !== 3'b111) begin
      errors++;
      $display("FAIL reset release s_ready: got %b expected 111", {r0, r1, r2});
    end
  endtask

  task automatic test_8n1;
    sel = 0;
    accept(9'h0A5, "8n1_a5");
    drive(1'b0, 9'h000);
    run_frame(9'h0A5, 8, 1, 0, 1000, 0, "8n1_a5");
    accept(9'h001, "8n1_01");
    drive(1'b0, 9'h000);
    run_frame(9'h001, 8, 1, 0, 1000, 0, "8n1_01");
    check_quiet(3, "8n1_after");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    sel = 0;
    accept(9'h0A5, "par_even_a5");
    drive(1'b0, 9'h000);
    run_frame(9'h0A5, 8, 1, 0, 1000, 0, "par_even_a5");
    accept(9'h0A4, "par_even_a4");
    drive(1'b0, 9'h000);
    run_frame(9'h0A4, 8, 1, 0, 1000, 0, "par_even_a4");
    sel = 2;
    accept(9'h003, "par_odd_03");
    drive(1'b0, 9'h000);
    run_frame(9'h003, 5, 1, 1, 1000, 0, "par_odd_03");
  endtask
`endif

  task automatic test_back_to_back;
    int low_end;
    int gap;
    sel = 1;
    accept(9'h000, "b2b_00");
    drive(1'b1, 9'h0FF);
    run_frame(9'h000, 8, 2, 0, 1000, 0, "b2b_00");
    low_end = last_low_cyc;
    run_frame(9'h0FF, 8, 2, 0, 1000, 0, "b2b_ff");
    drive(1'b0, 9'h000);
    gap = frame_start_cyc - low_end - 1;
    checks++;
    if (gap !== 2 * C + 1) begin
      errors++;
      $display("FAIL b2b gap: got %0d cycles expected %0d", gap, 2 * C + 1);
    end
    check_quiet(3, "b2b_after");
  endtask

  task automatic test_reset_mid;
    sel = 0;
    accept(9'h03C, "rst_3c");
    drive(1'b0, 9'h000);
    run_frame(9'h03C, 8, 1, 0, 4 * C + 5, 0, "rst_3c");
    #2;
    arst = 1'b1;
    #1;
    checks++;
    if ({q0, b0, dn0, r0} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid: q,busy,done,s_ready=%b expected 1000", {q0, b0, dn0, r0});
    end
    check_quiet(2, "reset_mid_held");
    arst = 1'b0;
    check_quiet(C + 5, "reset_mid_after");
    accept(9'h081, "rst_81");
    drive(1'b0, 9'h000);
    run_frame(9'h081, 8, 1, 0, 1000, 0, "rst_81");
  endtask

  task automatic test_midframe_valid;
    sel = 2;
    accept(9'h01F, "dw5_1f");
    drive(1'b0, 9'h000);
    run_frame(9'h01F, 5, 1, 1, 1000, 30, "dw5_1f");
    check_quiet(2 * C, "dw5_after");
  endtask

  initial begin
    test_reset();
    test_8n1();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid();
    test_midframe_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
